// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared decode constants and enums for the RV32M/RV64M
//               multiply/divide unit and its companion decode logic.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Main-decoder ALU op class for R-type instructions
    localparam logic [2:0] ALUOP_R       = 3'b001;
    // funct7 value that marks an M-extension instruction
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // The eight M-extension operations, encoded by funct3
    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    // Iterative unit control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/muldiv_decode.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_decode
// Description : Combinational classifier for M-extension instructions.
//               Flags the instruction as multiply/divide and derives the
//               operand signedness and high-half selection. Shared with the
//               hazard unit so both agree on which instructions are claimed.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_decode
    import riscv_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic       is_md,
    output logic       is_div,
    output logic       rs1_signed,
    output logic       rs2_signed,
    output logic       sel_high
);

    logic w_is_md;

    assign w_is_md = (aluop == ALUOP_R) && (funct7 == FUNCT7_MULDIV);

    // Per-operation attributes; everything is forced low for non-M instructions
    always_comb begin
        is_md      = w_is_md;
        is_div     = 1'b0;
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        sel_high   = 1'b0;
        if (w_is_md) begin
            case (funct3_e'(funct3))
                F3_MUL: begin
                end
                F3_MULH: begin
                    rs1_signed = 1'b1;
                    rs2_signed = 1'b1;
                    sel_high   = 1'b1;
                end
                F3_MULHSU: begin
                    rs1_signed = 1'b1;
                    sel_high   = 1'b1;
                end
                F3_MULHU: begin
                    sel_high   = 1'b1;
                end
                F3_DIV, F3_REM: begin
                    is_div     = 1'b1;
                    rs1_signed = 1'b1;
                    rs2_signed = 1'b1;
                end
                F3_DIVU, F3_REMU: begin
                    is_div     = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : muldiv_decode
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M/RV64M multiply/divide unit. Shift-add multiply
//               and restoring divide on operand magnitudes, one bit per cycle,
//               with sign correction folded into the final iteration. Divide
//               by zero and signed overflow resolve on the accept edge.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [2:0]      aluop_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            is_md_o,
    output logic            ready_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              CW     = $clog2(XLEN);
    localparam logic [CW-1:0]   c_last = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // Decode and accept
    // ------------------------------------------------------------------
    logic w_is_md;
    logic w_is_div;
    logic w_rs1_signed;
    logic w_rs2_signed;
    logic w_sel_high;

    muldiv_decode u_decode (
        .aluop      (aluop_i),
        .funct7     (funct7_i),
        .funct3     (funct3_i),
        .is_md      (w_is_md),
        .is_div     (w_is_div),
        .rs1_signed (w_rs1_signed),
        .rs2_signed (w_rs2_signed),
        .sel_high   (w_sel_high)
    );

    assign is_md_o = w_is_md;

    state_e r_state;
    state_e w_state_next;

    logic w_accept;
    assign w_accept = valid_i && (r_state == IDLE) && w_is_md;

    // Operand magnitudes and sign flags captured on accept
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    assign w_a_neg = w_rs1_signed & rs1_i[XLEN-1];
    assign w_b_neg = w_rs2_signed & rs2_i[XLEN-1];
    assign w_a_mag = w_a_neg ? (-rs1_i) : rs1_i;
    assign w_b_mag = w_b_neg ? (-rs2_i) : rs2_i;

    // Divide corner cases bypass the iteration entirely
    logic            w_div_zero;
    logic            w_div_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_div_zero = w_is_div && (rs2_i == '0);
    assign w_div_ovf  = w_is_div && w_rs1_signed && (rs1_i == c_min) && (rs2_i == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    // funct3[1] separates remainder from quotient within the divide group
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            w_special_res = funct3_i[1] ? rs1_i : '1;
        end else if (w_div_ovf) begin
            w_special_res = funct3_i[1] ? '0 : rs1_i;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    //   r_acc : multiply - {partial product high, remaining multiplier}
    //           divide   - {partial remainder, dividend/quotient shifter}
    //   r_op  : multiplicand magnitude or divisor magnitude
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_op;
    logic [CW-1:0]     r_cnt;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_sel_high;
    logic              r_sel_rem;
    logic [XLEN-1:0]   r_result;

    logic w_last;
    assign w_last = (r_cnt == c_last);

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_mul_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_op};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                                 : {1'b0, r_acc[2*XLEN-1:1]};
    assign w_mul_prod = r_neg_q ? (-w_mul_next) : w_mul_next;
    assign w_mul_res  = r_sel_high ? w_mul_prod[2*XLEN-1:XLEN] : w_mul_prod[XLEN-1:0];

    // Restoring step: shift in the next dividend bit, trial-subtract the
    // divisor and keep the difference only when it did not borrow.
    logic [XLEN:0]     w_div_shift;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ok;
    logic [XLEN-1:0]   w_div_rem;
    logic [2*XLEN-1:0] w_div_next;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_div_res;

    assign w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff  = w_div_shift - {1'b0, r_op};
    assign w_div_ok    = ~w_div_diff[XLEN];
    assign w_div_rem   = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
    assign w_div_next  = {w_div_rem, r_acc[XLEN-2:0], w_div_ok};
    assign w_quo       = w_div_next[XLEN-1:0];
    assign w_rem       = w_div_next[2*XLEN-1:XLEN];
    assign w_div_res   = r_sel_rem ? (r_neg_r ? (-w_rem) : w_rem)
                                   : (r_neg_q ? (-w_quo) : w_quo);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        busy_o       = 1'b0;
        valid_o      = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (w_accept) begin
                    if (w_special) begin
                        w_state_next = DONE;
                    end else if (w_is_div) begin
                        w_state_next = DIV;
                    end else begin
                        w_state_next = MUL;
                    end
                end
            end
            MUL, DIV: begin
                busy_o = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy_o       = 1'b1;
                valid_o      = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration and result write-back
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_acc      <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_sel_high <= 1'b0;
            r_sel_rem  <= 1'b0;
            r_result   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_sel_high <= w_sel_high;
                        r_sel_rem  <= funct3_i[1];
                        if (w_is_div) begin
                            r_acc <= {{XLEN{1'b0}}, w_a_mag};
                            r_op  <= w_b_mag;
                        end else begin
                            r_acc <= {{XLEN{1'b0}}, w_b_mag};
                            r_op  <= w_a_mag;
                        end
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_mul_res;
                    end
                end
                DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_div_res;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign result_o = r_result;

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: directed corner cases
//               followed by random operations, checked against an arithmetic
//               reference model, plus decode, ignore and reset-abort checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [2:0]      aluop_i;
    logic [6:0]      funct7_i;
    logic [2:0]      funct3_i;
    logic            valid_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            is_md_o;
    logic            ready_o;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .aluop_i  (aluop_i),
        .funct7_i (funct7_i),
        .funct3_i (funct3_i),
        .valid_i  (valid_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .is_md_o  (is_md_o),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M semantics computed with 64-bit integer arithmetic
    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0];  end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation, scramble inputs while it runs, check latency,
    // handshake behaviour and the returned value.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          exp_lat;
        int          lat;
        int          cyc;
        bit          hs_bad;
        exp     = ref_md(f3, a, b);
        exp_lat = is_special(f3, a, b) ? 1 : XLEN + 1;
        cyc = 0;
        while (!ready_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        check("ready_before_issue", ready_o, 1);
        aluop_i  = ALUOP_R;
        funct7_i = FUNCT7_MULDIV;
        funct3_i = f3;
        rs1_i    = a;
        rs2_i    = b;
        valid_i  = 1'b1;
        @(negedge clk_i);
        lat    = 0;
        cyc    = 1;
        hs_bad = 0;
        while (lat == 0 && cyc <= XLEN + 8) begin
            funct3_i = 3'($urandom);
            rs1_i    = $urandom;
            rs2_i    = $urandom;
            valid_i  = 1'($urandom);
            if (valid_o) begin
                lat = cyc;
            end else begin
                if (ready_o || !busy_o) hs_bad = 1;
                @(negedge clk_i);
                cyc++;
            end
        end
        valid_i = 1'b0;
        check($sformatf("latency f3=%0d", f3), 64'(lat), 64'(exp_lat));
        check($sformatf("result f3=%0d a=%h b=%h", f3, a, b), result_o, exp);
        check("handshake_while_running", hs_bad, 0);
        check("ready_low_at_valid", ready_o, 0);
        @(negedge clk_i);
        check("valid_single_pulse", valid_o, 0);
        check("ready_after_done", ready_o, 1);
        check("result_held", result_o, exp);
    endtask

    initial begin
        rst_i    = 1'b1;
        aluop_i  = 3'b000;
        funct7_i = 7'd0;
        funct3_i = 3'd0;
        valid_i  = 1'b0;
        rs1_i    = '0;
        rs2_i    = '0;
        repeat (2) @(negedge clk_i);
        check("reset_ready", ready_o, 1);
        check("reset_busy", busy_o, 0);
        check("reset_valid", valid_o, 0);
        check("reset_result", result_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed cases
        do_op(3'b000, 32'd7,         32'hFFFF_FFFD);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2);
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2);
        do_op(3'b101, 32'd100,       32'd7);
        do_op(3'b111, 32'd100,       32'd7);
        do_op(3'b101, 32'd5,         32'd0);
        do_op(3'b111, 32'd5,         32'd0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

        // Non-M requests are ignored; decode is combinational
        aluop_i  = 3'b010;
        funct7_i = FUNCT7_MULDIV;
        funct3_i = 3'b000;
        valid_i  = 1'b1;
        #1 check("is_md_bad_aluop", is_md_o, 0);
        @(negedge clk_i);
        check("ignore_bad_aluop_ready", ready_o, 1);
        check("ignore_bad_aluop_busy", busy_o, 0);
        aluop_i  = ALUOP_R;
        funct7_i = 7'd0;
        #1 check("is_md_bad_funct7", is_md_o, 0);
        @(negedge clk_i);
        check("ignore_bad_funct7_ready", ready_o, 1);
        valid_i  = 1'b0;
        funct7_i = FUNCT7_MULDIV;
        #1 check("is_md_claimed", is_md_o, 1);
        @(negedge clk_i);
        check("no_accept_without_valid", ready_o, 1);

        // Reset in cycle 10 of a divide aborts it
        aluop_i  = ALUOP_R;
        funct7_i = FUNCT7_MULDIV;
        funct3_i = 3'b100;
        rs1_i    = 32'd1000;
        rs2_i    = 32'd7;
        valid_i  = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (9) @(negedge clk_i);
        check("busy_before_abort", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("abort_ready", ready_o, 1);
        check("abort_valid", valid_o, 0);
        check("abort_result", result_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        begin
            bit saw_valid;
            saw_valid = 0;
            for (int i = 0; i < XLEN + 4; i++) begin
                @(negedge clk_i);
                if (valid_o) saw_valid = 1;
            end
            check("no_valid_after_abort", saw_valid, 0);
        end
        do_op(3'b000, 32'd12345, 32'd678);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            do_op(3'($urandom), pick_operand(), pick_operand());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
